// File: rtl/vga_mem_arb_pkg.sv
// Shared definitions for the VGA memory arbiter.
//   - FSM state encodings (IDLE, BUSY, DONE)
//   - requester identifiers (DISP, PCI, CPU)
//   - wait-counter width (holds any TIMEOUT value from 1 to 255)
package vga_mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] DISP = 2'd0;
    localparam logic [1:0] PCI  = 2'd1;
    localparam logic [1:0] CPU  = 2'd2;

    localparam int WAIT_WIDTH = 8;

endpackage

// File: rtl/vga_mem_arb_pick.sv
// Combinational grant selection for the VGA memory arbiter.
// Ports:
//   d_req, p_req, v_req  in   pending display / PCI / CPU requests
//   last_pci             in   1 = PCI was the last PCI/CPU grant, so CPU wins a tie
//   any_req              out  at least one request is pending
//   grant                out  requester ID of the winner (DISP/PCI/CPU)
module vga_mem_arb_pick
    import vga_mem_arb_pkg::*;
(
    input  logic       d_req,
    input  logic       p_req,
    input  logic       v_req,
    input  logic       last_pci,
    output logic       any_req,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        any_req = d_req | p_req | v_req;
        grant   = DISP;
        if (d_req) begin
            grant = DISP;
        end else if (p_req && v_req) begin
            grant = last_pci ? CPU : PCI;
        end else if (p_req) begin
            grant = PCI;
        end else if (v_req) begin
            grant = CPU;
        end
    end

endmodule

// File: rtl/vga_mem_arb.sv
// Three-way memory arbiter: display refresh (absolute priority), PCI direct
// access and TTA CPU (round-robin between the two). One transaction at a time,
// with a wait timeout that completes the transaction with an all-ones result.
// Ports:
//   clock_i, reset_ni                 clock, synchronous active-low reset
//   d_read_i, d_addr_i                display read request / address
//   d_ready_o, d_data_o               display completion pulse / read data
//   p_read_i, p_write_i, p_addr_i,    PCI request, address, write data
//   p_data_i
//   p_ready_o, p_data_o, p_err_o      PCI completion pulse / data / timeout flag
//   v_read_i, v_write_i, v_addr_i,    CPU request, address, write data
//   v_data_i
//   v_ready_o, v_data_o, v_err_o      CPU completion pulse / data / timeout flag
//   m_read_o, m_write_o, m_addr_o,    memory strobes, address, write data
//   m_data_o
//   m_ready_i, m_data_i               memory completion / read data
module vga_mem_arb
    import vga_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  d_read_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    input  logic                  p_read_i,
    input  logic                  p_write_i,
    input  logic [ADDR_WIDTH-1:0] p_addr_i,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    output logic                  p_ready_o,
    output logic [DATA_WIDTH-1:0] p_data_o,
    output logic                  p_err_o,
    input  logic                  v_read_i,
    input  logic                  v_write_i,
    input  logic [ADDR_WIDTH-1:0] v_addr_i,
    input  logic [DATA_WIDTH-1:0] v_data_i,
    output logic                  v_ready_o,
    output logic [DATA_WIDTH-1:0] v_data_o,
    output logic                  v_err_o,
    output logic                  m_read_o,
    output logic                  m_write_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    input  logic [DATA_WIDTH-1:0] m_data_i
);

    // The counter value seen in the last BUSY cycle before a timeout; the
    // count reaches TIMEOUT on the edge that forces DONE.
    localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [1:0]            grant;
    logic                  last_pci;
    logic [WAIT_WIDTH-1:0] wait_cnt;

    logic                  any_req;
    logic [1:0]            pick;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] done_data;

    vga_mem_arb_pick u_pick (
        .d_req    (d_read_i),
        .p_req    (p_read_i | p_write_i),
        .v_req    (v_read_i | v_write_i),
        .last_pci (last_pci),
        .any_req  (any_req),
        .grant    (pick)
    );

    // Read+write together counts as a write; reads present zero write data.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = d_addr_i;
        sel_wdata = '0;
        case (pick)
            PCI: begin
                sel_write = p_write_i;
                sel_addr  = p_addr_i;
                sel_wdata = p_write_i ? p_data_i : '0;
            end
            CPU: begin
                sel_write = v_write_i;
                sel_addr  = v_addr_i;
                sel_wdata = v_write_i ? v_data_i : '0;
            end
            default: ;
        endcase
    end

    assign timeout_hit = (wait_cnt == LAST_WAIT);
    // A real completion always wins over a timeout in the same cycle.
    assign done_data   = m_ready_i ? m_data_i : '1;

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state     <= ST_IDLE;
            grant     <= DISP;
            last_pci  <= 1'b1;
            wait_cnt  <= '0;
            m_read_o  <= 1'b0;
            m_write_o <= 1'b0;
            m_addr_o  <= '0;
            m_data_o  <= '0;
            d_ready_o <= 1'b0;
            d_data_o  <= '0;
            p_ready_o <= 1'b0;
            p_data_o  <= '0;
            p_err_o   <= 1'b0;
            v_ready_o <= 1'b0;
            v_data_o  <= '0;
            v_err_o   <= 1'b0;
        end else begin
            d_ready_o <= 1'b0;
            p_ready_o <= 1'b0;
            p_err_o   <= 1'b0;
            v_ready_o <= 1'b0;
            v_err_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_BUSY;
                        grant     <= pick;
                        wait_cnt  <= '0;
                        m_addr_o  <= sel_addr;
                        m_data_o  <= sel_wdata;
                        m_write_o <= sel_write;
                        m_read_o  <= ~sel_write;
                    end
                end
                ST_BUSY: begin
                    if (!m_ready_i) begin
                        wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
                    end
                    if (m_ready_i || timeout_hit) begin
                        state     <= ST_DONE;
                        m_read_o  <= 1'b0;
                        m_write_o <= 1'b0;
                        case (grant)
                            DISP: begin
                                d_ready_o <= 1'b1;
                                d_data_o  <= done_data;
                            end
                            PCI: begin
                                p_ready_o <= 1'b1;
                                p_data_o  <= done_data;
                                p_err_o   <= ~m_ready_i;
                                last_pci  <= 1'b1;
                            end
                            CPU: begin
                                v_ready_o <= 1'b1;
                                v_data_o  <= done_data;
                                v_err_o   <= ~m_ready_i;
                                last_pci  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arb.sv
// Self-checking bench for vga_mem_arb. Expected transactions are queued in
// grant order when requests are issued; a per-cycle step (run on the falling
// edge) checks the memory side when a strobe starts, models the memory
// response, and checks the completion pulse / data / error flags.
module tb_vga_mem_arb;
    import vga_mem_arb_pkg::*;

    localparam int AW         = 20;
    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 16;

    logic          clock_i;
    logic          reset_ni;
    logic          d_read_i;
    logic [AW-1:0] d_addr_i;
    logic          d_ready_o;
    logic [DW-1:0] d_data_o;
    logic          p_read_i, p_write_i;
    logic [AW-1:0] p_addr_i;
    logic [DW-1:0] p_data_i;
    logic          p_ready_o;
    logic [DW-1:0] p_data_o;
    logic          p_err_o;
    logic          v_read_i, v_write_i;
    logic [AW-1:0] v_addr_i;
    logic [DW-1:0] v_data_i;
    logic          v_ready_o;
    logic [DW-1:0] v_data_o;
    logic          v_err_o;
    logic          m_read_o, m_write_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_i;

    vga_mem_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .d_read_i  (d_read_i),
        .d_addr_i  (d_addr_i),
        .d_ready_o (d_ready_o),
        .d_data_o  (d_data_o),
        .p_read_i  (p_read_i),
        .p_write_i (p_write_i),
        .p_addr_i  (p_addr_i),
        .p_data_i  (p_data_i),
        .p_ready_o (p_ready_o),
        .p_data_o  (p_data_o),
        .p_err_o   (p_err_o),
        .v_read_i  (v_read_i),
        .v_write_i (v_write_i),
        .v_addr_i  (v_addr_i),
        .v_data_i  (v_data_i),
        .v_ready_o (v_ready_o),
        .v_data_o  (v_data_o),
        .v_err_o   (v_err_o),
        .m_read_o  (m_read_o),
        .m_write_o (m_write_o),
        .m_addr_o  (m_addr_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .m_data_i  (m_data_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [1:0]    id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            lat;   // strobe cycles before memory answers; 0 = never
        logic          err;
    } item_t;

    item_t         sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            strobe_cnt = 0;
    int            d_left = 0, p_left = 0, v_left = 0;
    logic          p_we = 1'b0, v_we = 1'b0, v_both = 1'b0;
    logic          idle_poke = 1'b0;
    logic [DW-1:0] exp_data [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input int lat);
        item_t it;
        it.id = id; it.we = we; it.addr = addr; it.wdata = wdata;
        it.rdata = rdata; it.lat = lat; it.err = (lat == 0);
        sb.push_back(it);
    endtask

    task automatic drive_reqs();
        d_read_i  = (d_left > 0);
        p_read_i  = (p_left > 0) && (!p_we);
        p_write_i = (p_left > 0) && p_we;
        v_read_i  = (v_left > 0) && (!v_we || v_both);
        v_write_i = (v_left > 0) && v_we;
    endtask

    // One falling-edge step: check outputs, then drive memory and requests.
    task automatic step();
        item_t         it;
        logic          strobe;
        logic [1:0]    got_id;
        logic [DW-1:0] exp_val;
        strobe = m_read_o | m_write_o;
        if (d_ready_o | p_ready_o | v_ready_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                got_id = d_ready_o ? DISP : (p_ready_o ? PCI : CPU);
                check("ready_onehot", 32'(d_ready_o) + 32'(p_ready_o) + 32'(v_ready_o), 32'd1);
                check("grant_id", 32'(got_id), 32'(it.id));
                check("strobe_cycles", strobe_cnt, it.err ? TB_TIMEOUT : it.lat);
                check("strobe_in_done", 32'(strobe), 32'd0);
                exp_val = it.err ? '1 : it.rdata;
                exp_data[it.id] = exp_val;
                check("d_data", d_data_o, exp_data[DISP]);
                check("p_data", p_data_o, exp_data[PCI]);
                check("v_data", v_data_o, exp_data[CPU]);
                check("p_err", 32'(p_err_o), 32'(it.id == PCI && it.err));
                check("v_err", 32'(v_err_o), 32'(it.id == CPU && it.err));
                case (it.id)
                    DISP:    d_left--;
                    PCI:     p_left--;
                    default: v_left--;
                endcase
            end
            strobe_cnt = 0;
        end
        if (strobe) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
                m_ready_i = 1'b0;
            end else begin
                it = sb[0];
                if (strobe_cnt == 0) begin
                    check("m_write", 32'(m_write_o), 32'(it.we));
                    check("m_read", 32'(m_read_o), 32'(!it.we));
                    check("m_data", m_data_o, it.we ? it.wdata : 32'd0);
                end
                check("m_addr", 32'(m_addr_o), 32'(it.addr));
                strobe_cnt++;
                m_ready_i = (it.lat != 0) && (strobe_cnt == it.lat);
                m_data_i  = m_ready_i ? it.rdata : $urandom;
            end
        end else begin
            m_ready_i = idle_poke;
            m_data_i  = $urandom;
        end
        drive_reqs();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || d_left != 0 || p_left != 0 || v_left != 0) && n < budget) begin
            @(negedge clock_i);
            step();
            n++;
        end
        check("run_drained", sb.size(), 0);
        sb.delete();
        d_left = 0; p_left = 0; v_left = 0;
        drive_reqs();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, {30'd0, m_read_o, m_write_o}, 32'd0);
        check({tag, "_readies"}, {29'd0, d_ready_o, p_ready_o, v_ready_o}, 32'd0);
        check({tag, "_errs"}, {30'd0, p_err_o, v_err_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) exp_data[i] = '0;
        reset_ni = 1'b0;
        m_ready_i = 1'b0; m_data_i = '0;
        d_addr_i = '0; p_addr_i = '0; v_addr_i = '0; p_data_i = '0; v_data_i = '0;
        drive_reqs();
        d_read_i = 1'b1;   // a request during reset must be ignored
        repeat (3) @(negedge clock_i);
        check_quiet("rst");
        check("rst_m_addr", 32'(m_addr_o), 32'd0);
        check("rst_m_data", m_data_o, 32'd0);
        check("rst_d_data", d_data_o, 32'd0);
        check("rst_p_data", p_data_o, 32'd0);
        check("rst_v_data", v_data_o, 32'd0);
        d_read_i = 1'b0;
        reset_ni = 1'b1;

        // Memory ready while idle changes nothing.
        idle_poke = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_i);
            step();
            check_quiet("idle_poke");
            check("idle_poke_v_data", v_data_o, 32'd0);
        end
        idle_poke = 1'b0;

        // All three request: display, then CPU, then PCI; then alternation.
        d_addr_i = 20'h00100; p_addr_i = 20'h00200; v_addr_i = 20'h00300;
        p_we = 1'b0; v_we = 1'b0;
        push(DISP, 1'b0, 20'h00100, '0, 32'hA0A0_0001, 1);
        push(CPU,  1'b0, 20'h00300, '0, 32'hC0C0_0001, 2);
        push(PCI,  1'b0, 20'h00200, '0, 32'hB0B0_0001, 1);
        push(CPU,  1'b0, 20'h00300, '0, 32'hC0C0_0002, 1);
        push(PCI,  1'b0, 20'h00200, '0, 32'hB0B0_0002, 3);
        d_left = 1; p_left = 2; v_left = 2;
        drive_reqs();
        run(200);

        // CPU read, memory answers in the third strobe cycle.
        v_addr_i = 20'h00010; v_we = 1'b0;
        push(CPU, 1'b0, 20'h00010, '0, 32'hDEAD_BEEF, 3);
        v_left = 1; drive_reqs();
        run(100);

        // PCI write.
        p_addr_i = 20'h0ABCD; p_data_i = 32'h1234_5678; p_we = 1'b1;
        push(PCI, 1'b1, 20'h0ABCD, 32'h1234_5678, 32'h7777_0037, 2);
        p_left = 1; drive_reqs();
        run(100);

        // CPU asserting read and write together is a write.
        v_addr_i = 20'h00700; v_data_i = 32'h5A5A_0019; v_we = 1'b1; v_both = 1'b1;
        push(CPU, 1'b1, 20'h00700, 32'h5A5A_0019, 32'h0000_1919, 1);
        v_left = 1; drive_reqs();
        run(100);
        v_we = 1'b0; v_both = 1'b0;

        // Timeouts: memory never answers.
        v_addr_i = 20'h00400;
        push(CPU, 1'b0, 20'h00400, '0, '0, 0);
        v_left = 1; drive_reqs();
        run(100);
        d_addr_i = 20'h00500;
        push(DISP, 1'b0, 20'h00500, '0, '0, 0);
        d_left = 1; drive_reqs();
        run(100);
        p_addr_i = 20'h00550; p_we = 1'b0;
        push(PCI, 1'b0, 20'h00550, '0, '0, 0);
        p_left = 1; drive_reqs();
        run(100);

        // Reset in the second BUSY cycle abandons the transaction.
        v_addr_i = 20'h00600;
        push(CPU, 1'b0, 20'h00600, '0, 32'h0000_0001, 0);
        v_left = 1; drive_reqs();
        for (int i = 0; i < 20 && strobe_cnt < 2; i++) begin
            @(negedge clock_i);
            step();
        end
        check("rst_mid_reached_busy", strobe_cnt, 2);
        reset_ni = 1'b0;
        @(negedge clock_i);
        check_quiet("rst_mid");
        check("rst_mid_v_data", v_data_o, 32'd0);
        sb.delete();
        d_left = 0; p_left = 0; v_left = 0; strobe_cnt = 0;
        m_ready_i = 1'b0;
        drive_reqs();
        for (int i = 0; i < 3; i++) exp_data[i] = '0;
        reset_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            step();
            check_quiet("post_rst");
        end

        // Arbitration resumes; after reset the CPU wins the tie.
        p_addr_i = 20'h00800; v_addr_i = 20'h00900; p_we = 1'b0; v_we = 1'b0;
        push(CPU, 1'b0, 20'h00900, '0, 32'h0900_0900, 2);
        push(PCI, 1'b0, 20'h00800, '0, 32'h0800_0800, 1);
        p_left = 1; v_left = 1; drive_reqs();
        run(100);

        repeat (3) begin
            @(negedge clock_i);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
